rsa_stream_ctrl: RTL and testbench
==================================

// Module: rsa_stream_ctrl
// PURPOSE
//   Job-level initiator for the systolic array input/output port. On a start pulse it streams
//   operand A (X×N) and operand B (N×Y) from operand RAMs as Xin_val/Xin_data and Yin_val/Yin_data.
//   It then waits a fixed compute latency and raises out_val. It captures out_data into the result
//   RAM. It sits between the EKF datapath sequencer (start/done) and the port's wr/rd enable generator.
// PARAMETERS
//   X           3   array rows (rows of A / C)
//   N           4   inner dimension (cols of A, rows of B)
//   Y           3   array cols (cols of B / C)
//   IN_LEN      8   operand word width
//   OUT_LEN     8   result word width
//   AW          4   operand/result RAM address width; must satisfy 2**AW >= max(X*N, N*Y, X*Y)
//   COMP_LAT    8   cycles between last operand word and out_val rise (0 allowed)
// PORTS
//   clk        in   1        clock
//   sys_rst_n  in   1        asynchronous active-low reset
//   start      in   1        job request; sampled only in IDLE
//   busy       out  1        high from the cycle after start accept through the DONE cycle
//   done       out  1        one-cycle pulse at job end
//   a_rd_en    out  1        A RAM read strobe; RAM has 1-cycle read latency
//   a_rd_addr  out  AW       A address, row-major r*N+k
//   a_rd_data  in   IN_LEN   A RAM data
//   b_rd_en    out  1        B RAM read strobe; RAM has 1-cycle read latency
//   b_rd_addr  out  AW       B address, row-major k*Y+c
//   b_rd_data  in   IN_LEN   B RAM data
//   Xin_val    out  1        west stream window
//   Xin_data   out  IN_LEN   west data
//   Yin_val    out  1        north stream window
//   Yin_data   out  IN_LEN   north data
//   out_val    out  1        result drain window
//   out_data   in   OUT_LEN  array result, row-selected by the port's out_rd_en
//   c_wr_en    out  1        result RAM write strobe
//   c_wr_addr  out  AW       result address, row-major r*Y+c
//   c_wr_data  out  OUT_LEN  result write data
// BEHAVIOUR
//   Reset: all outputs are 0, state is IDLE, all counters are 0. Reset mid-job aborts the job
//     without emitting done; the next start begins a fresh job.
//   FSM: IDLE -> LOAD -> WAIT -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 accepts the job and moves to LOAD on the next edge. busy=0.
//   LOAD: Xin_val=1 for exactly X*N consecutive cycles, starting at LOAD entry t0.
//     a_rd_en=Xin_val; a_rd_addr=0..X*N-1, one per cycle.
//     Xin_data = a_rd_data (combinational pass-through). Word i is therefore valid at t0+1+i,
//     one cycle after Xin_val, aligned to the port's registered westin_wr_en.
//   LOAD (north): Yin_val=1 for exactly N*Y cycles from t0. b_rd_en=Yin_val; b_rd_addr=0..N*Y-1.
//     Yin_data word j is valid at t0+1+j (column j%Y, k=j/Y).
//   The X and Y windows are independent; each val drops when its own count completes.
//   LOAD exits one cycle after the later window ends, i.e. after max(X*N,N*Y)+1 cycles,
//     so the last data word is presented.
//   WAIT: a counter runs COMP_LAT cycles. With COMP_LAT=0, WAIT lasts 0 cycles and goes to DRAIN.
//   DRAIN: out_val=1 for exactly X*Y cycles from entry d0.
//     Capture is one cycle late: c_wr_en=1 at d0+1..d0+X*Y.
//     c_wr_addr = 0..X*Y-1; c_wr_data = out_data sampled in that cycle.
//     DRAIN exits after X*Y+1 cycles.
//   DONE: done=1 for one cycle; all val signals are 0; then IDLE.
//   Every val is low for at least 2 cycles between jobs, so the port always sees a clean rising edge.
//   start while busy: ignored, not queued. start held high continuously: a new job starts on the
//     first IDLE cycle after DONE.
//   Counters are sized $clog2 of their terminal count + 1. There is no wrap-around inside a job;
//     the terminal compare is exact equality to count-1.
// CONFIGURATION
//   RSA_STREAM_PERF_EN defined: adds output perf_cycles [15:0].
//     The counter clears on job accept and increments every busy cycle (saturating at 16'hFFFF).
//     Its value is held stable from the DONE cycle until the next accept. Reset value is 0.
//   RSA_STREAM_PERF_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//   1 Defaults, A[i]=i+1, B[j]=j+17, start pulse -> Xin_val high 12 cycles, Xin_data 1..12 on
//     t0+1..t0+12; Yin_data 17..28; done exactly 12+1+8+9+1 cycles after LOAD entry.
//   2 Array model drives out_data=row*16+col -> result RAM holds 0x00,0x01,0x02,0x10..0x22 at
//     addresses 0..8; c_wr_en high exactly 9 cycles.
//   3 start re-pulsed during LOAD and DRAIN -> ignored; exactly one done pulse; RAM read count is 24.
//   4 start tied high for 3 jobs -> 3 done pulses; Xin_val/Yin_val/out_val each low >=2 cycles
//     between windows.
//   5 sys_rst_n asserted at LOAD cycle 5 -> all outputs 0 immediately; no done; next start runs
//     a full job identical to test 1.
//   6 COMP_LAT=0, X=2,N=5,Y=4 -> Xin_val 10 cycles, Yin_val 20 cycles, out_val rises the cycle
//     after LOAD exit; with RSA_STREAM_PERF_EN, perf_cycles = 21+0+9+1 = 31.

Source files
------------

// File: rtl/rsa_stream_ctrl_if.sv
// Bus bundle between the stream controller and its environment: job control
// (start/busy/done), operand RAM read ports, west/north operand streams,
// result drain window and the result RAM write port.
interface rsa_stream_ctrl_if #(
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 8,
  parameter int AW      = 4
);
  logic               start;
  logic               busy;
  logic               done;
  logic               a_rd_en;
  logic [AW-1:0]      a_rd_addr;
  logic [IN_LEN-1:0]  a_rd_data;
  logic               b_rd_en;
  logic [AW-1:0]      b_rd_addr;
  logic [IN_LEN-1:0]  b_rd_data;
  logic               Xin_val;
  logic [IN_LEN-1:0]  Xin_data;
  logic               Yin_val;
  logic [IN_LEN-1:0]  Yin_data;
  logic               out_val;
  logic [OUT_LEN-1:0] out_data;
  logic               c_wr_en;
  logic [AW-1:0]      c_wr_addr;
  logic [OUT_LEN-1:0] c_wr_data;

  // Controller side
  modport master (
    input  start, a_rd_data, b_rd_data, out_data,
    output busy, done,
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    output Xin_val, Xin_data, Yin_val, Yin_data,
    output out_val, c_wr_en, c_wr_addr, c_wr_data
  );

  // Environment side (sequencer, RAMs, array port)
  modport slave (
    output start, a_rd_data, b_rd_data, out_data,
    input  busy, done,
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    input  Xin_val, Xin_data, Yin_val, Yin_data,
    input  out_val, c_wr_en, c_wr_addr, c_wr_data
  );
endinterface

// File: rtl/rsa_stream_ctrl.sv
// rsa_stream_ctrl: job-level initiator for the systolic array port.
// Streams operand A (X*N) and B (N*Y) from 1-cycle-latency RAMs, waits
// COMP_LAT cycles, opens the out_val drain window and writes the results
// (captured one cycle late) into the result RAM.
// Optional feature macro: RSA_STREAM_PERF_EN adds the perf_cycles output.
module rsa_stream_ctrl #(
  parameter int X        = 3,
  parameter int N        = 4,
  parameter int Y        = 3,
  parameter int IN_LEN   = 8,
  parameter int OUT_LEN  = 8,
  parameter int AW       = 4,
  parameter int COMP_LAT = 8
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  rsa_stream_ctrl_if.master bus
`ifdef RSA_STREAM_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam int XN        = X * N;
  localparam int NY        = N * Y;
  localparam int XY        = X * Y;
  // LOAD lasts one cycle past the longer window so its last word is presented
  localparam int LOAD_TERM = (XN > NY) ? XN : NY;
  localparam int XW        = $clog2(XN + 1);
  localparam int YW        = $clog2(NY + 1);
  localparam int LW        = $clog2(LOAD_TERM + 1);
  localparam int DW        = $clog2(XY + 1);
  localparam int WW        = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(XN - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(NY - 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_TERM);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(XY);
  localparam logic [WW-1:0] WAIT_LAST = WW'((COMP_LAT > 0) ? COMP_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_accept;
  logic          w_out_val;

  logic          r_xin_val;
  logic          r_yin_val;
  logic          r_xin_dv;
  logic          r_yin_dv;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic [LW-1:0] r_load_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic          r_c_wr_en;
  logic [AW-1:0] r_c_wr_addr;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_out_val = (r_state == S_DRAIN) && (r_drain_cnt != DRAIN_LAST);

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state logic; start is only looked at in IDLE so re-pulses are dropped
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_LOAD;
      S_LOAD:  if (r_load_cnt == LOAD_LAST)
                 w_state_next = (COMP_LAT == 0) ? S_DRAIN : S_WAIT;
      S_WAIT:  if (r_wait_cnt == WAIT_LAST) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Stream windows, phase counters and the one-cycle-late capture pipeline
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_xin_val   <= 1'b0;
      r_yin_val   <= 1'b0;
      r_xin_dv    <= 1'b0;
      r_yin_dv    <= 1'b0;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_load_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_c_wr_en   <= 1'b0;
      r_c_wr_addr <= '0;
    end else begin
      // RAM data lags the read strobe by one cycle
      r_xin_dv    <= r_xin_val;
      r_yin_dv    <= r_yin_val;
      r_c_wr_en   <= w_out_val;
      r_c_wr_addr <= w_out_val ? AW'(r_drain_cnt) : '0;

      if (w_accept) begin
        r_xin_val   <= 1'b1;
        r_yin_val   <= 1'b1;
        r_x_cnt     <= '0;
        r_y_cnt     <= '0;
        r_load_cnt  <= '0;
        r_wait_cnt  <= '0;
        r_drain_cnt <= '0;
      end else begin
        // Each window closes on its own terminal count
        if (r_xin_val) begin
          if (r_x_cnt == X_LAST) r_xin_val <= 1'b0;
          else                   r_x_cnt   <= r_x_cnt + 1'b1;
        end
        if (r_yin_val) begin
          if (r_y_cnt == Y_LAST) r_yin_val <= 1'b0;
          else                   r_y_cnt   <= r_y_cnt + 1'b1;
        end
        if (r_state == S_LOAD)
          r_load_cnt <= (r_load_cnt == LOAD_LAST) ? '0 : r_load_cnt + 1'b1;
        if (r_state == S_WAIT)
          r_wait_cnt <= (r_wait_cnt == WAIT_LAST) ? '0 : r_wait_cnt + 1'b1;
        if (r_state == S_DRAIN)
          r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? '0 : r_drain_cnt + 1'b1;
      end
    end
  end

  // Outputs: addresses and data are forced to zero outside their windows
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.a_rd_en   = r_xin_val;
  assign bus.a_rd_addr = r_xin_val ? AW'(r_x_cnt) : '0;
  assign bus.b_rd_en   = r_yin_val;
  assign bus.b_rd_addr = r_yin_val ? AW'(r_y_cnt) : '0;
  assign bus.Xin_val   = r_xin_val;
  assign bus.Xin_data  = r_xin_dv ? bus.a_rd_data : {IN_LEN{1'b0}};
  assign bus.Yin_val   = r_yin_val;
  assign bus.Yin_data  = r_yin_dv ? bus.b_rd_data : {IN_LEN{1'b0}};
  assign bus.out_val   = w_out_val;
  assign bus.c_wr_en   = r_c_wr_en;
  assign bus.c_wr_addr = r_c_wr_addr;
  assign bus.c_wr_data = r_c_wr_en ? bus.out_data : {OUT_LEN{1'b0}};

`ifdef RSA_STREAM_PERF_EN
  logic [15:0] r_perf;

  // Busy-cycle counter: shows busy cycles elapsed including the current one,
  // so the DONE cycle already presents the final job length, held until next accept
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_perf <= 16'd0;
    else if (w_accept)
      r_perf <= 16'd1;
    else if ((r_state != S_IDLE) && (r_state != S_DONE) && (r_perf != 16'hFFFF))
      r_perf <= r_perf + 16'd1;
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Directed bench for rsa_stream_ctrl: default-parameter instance for stream,
// drain, start-filtering, back-to-back and mid-job reset scenarios, plus a
// second instance with X=2,N=5,Y=4,COMP_LAT=0 for the zero-latency case.
module tb_rsa_stream_ctrl;

  logic clk;
  logic sys_rst_n;

  int n_chk;
  int n_fail;
  int n_wr;

  rsa_stream_ctrl_if #(.IN_LEN(8), .OUT_LEN(8), .AW(4)) u_if ();
  rsa_stream_ctrl_if #(.IN_LEN(8), .OUT_LEN(8), .AW(5)) u_if2 ();

`ifdef RSA_STREAM_PERF_EN
  logic [15:0] perf1;
  logic [15:0] perf2;
`endif

  rsa_stream_ctrl #(.X(3), .N(4), .Y(3), .IN_LEN(8), .OUT_LEN(8), .AW(4), .COMP_LAT(8)) u_dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (u_if)
`ifdef RSA_STREAM_PERF_EN
    ,
    .perf_cycles (perf1)
`endif
  );

  rsa_stream_ctrl #(.X(2), .N(5), .Y(4), .IN_LEN(8), .OUT_LEN(8), .AW(5), .COMP_LAT(0)) u_dut2 (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (u_if2)
`ifdef RSA_STREAM_PERF_EN
    ,
    .perf_cycles (perf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand RAMs: A[i]=i+1, B[j]=j+17, one-cycle registered read
  always @(posedge clk) begin
    if (u_if.a_rd_en)  u_if.a_rd_data  <= {4'b0, u_if.a_rd_addr} + 8'd1;
    if (u_if.b_rd_en)  u_if.b_rd_data  <= {4'b0, u_if.b_rd_addr} + 8'd17;
    if (u_if2.a_rd_en) u_if2.a_rd_data <= {3'b0, u_if2.a_rd_addr} + 8'd1;
    if (u_if2.b_rd_en) u_if2.b_rd_data <= {3'b0, u_if2.b_rd_addr} + 8'd17;
  end

  // Array model: element k of the drain is presented the cycle after its out_val cycle
  int k_idx;
  initial k_idx = 0;
  always @(posedge clk) begin
    if (u_if.out_val) begin
      u_if.out_data <= 8'(((k_idx / 3) * 16) + (k_idx % 3));
      k_idx <= k_idx + 1;
    end else begin
      u_if.out_data <= 8'd0;
      k_idx <= 0;
    end
  end
  assign u_if2.out_data = 8'd0;

  // Result RAM
  logic [7:0] c_ram [16];
  initial n_wr = 0;
  always @(posedge clk) begin
    if (u_if.c_wr_en) begin
      c_ram[u_if.c_wr_addr] <= u_if.c_wr_data;
      n_wr <= n_wr + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full job on the default instance with per-cycle expectations
  task automatic run_job(input string tag);
    int w0;
    int dpos;
    w0   = n_wr;
    dpos = -1;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    for (int c = 0; c < 35; c++) begin
      chk({tag, " Xin_val"},  u_if.Xin_val,  (c < 12));
      chk({tag, " Yin_val"},  u_if.Yin_val,  (c < 12));
      chk({tag, " a_rd_addr"}, u_if.a_rd_addr, (c < 12) ? c : 0);
      chk({tag, " Xin_data"}, u_if.Xin_data, (c >= 1 && c <= 12) ? c : 0);
      chk({tag, " Yin_data"}, u_if.Yin_data, (c >= 1 && c <= 12) ? c + 16 : 0);
      chk({tag, " out_val"},  u_if.out_val,  (c >= 21 && c <= 29));
      chk({tag, " c_wr_en"},  u_if.c_wr_en,  (c >= 22 && c <= 30));
      chk({tag, " busy"},     u_if.busy,     (c <= 31));
      chk({tag, " done"},     u_if.done,     (c == 31));
      if (u_if.done) dpos = c;
      tick();
    end
    chk({tag, " writes"}, n_wr - w0, 9);
    for (int a = 0; a < 9; a++)
      chk({tag, " c_ram"}, c_ram[a], ((a / 3) * 16) + (a % 3));
    $display("job %s: done at offset %0d, %0d result writes", tag, dpos, n_wr - w0);
  endtask

  int done_cnt;
  int rd_cnt;
  int cyc;
  int done_at [3];
  int low_run [3];
  int min_gap [3];
  bit seen_hi [3];
  bit prev_v  [3];
  logic [2:0] vals;

  initial begin
    n_chk = 0;
    n_fail = 0;
    u_if.start  = 1'b0;
    u_if2.start = 1'b0;
    sys_rst_n   = 1'b1;
    #2 sys_rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst busy",     u_if.busy,     0);
    chk("rst done",     u_if.done,     0);
    chk("rst Xin_val",  u_if.Xin_val,  0);
    chk("rst Yin_val",  u_if.Yin_val,  0);
    chk("rst out_val",  u_if.out_val,  0);
    chk("rst c_wr_en",  u_if.c_wr_en,  0);
    chk("rst a_rd_en",  u_if.a_rd_en,  0);
    chk("rst Xin_data", u_if.Xin_data, 0);
    sys_rst_n = 1'b1;
    tick();

    // Streams, latency and drain
    run_job("t1");

    // Start re-pulsed inside LOAD and DRAIN
    done_cnt = 0;
    rd_cnt   = 0;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      u_if.start = (c == 3 || c == 25);
      rd_cnt   += int'(u_if.a_rd_en) + int'(u_if.b_rd_en);
      done_cnt += int'(u_if.done);
      if (c == 33) chk("t3 no requeue busy", u_if.busy, 0);
      tick();
    end
    u_if.start = 1'b0;
    chk("t3 done pulses", done_cnt, 1);
    chk("t3 ram reads", rd_cnt, 24);
    $display("job t3: %0d done pulses, %0d operand reads", done_cnt, rd_cnt);

    // Start held high for three jobs
    done_cnt = 0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      low_run[i] = 0;
      min_gap[i] = 1000;
      seen_hi[i] = 1'b0;
      prev_v[i]  = 1'b0;
    end
    u_if.start = 1'b1;
    tick();
    while (done_cnt < 3 && cyc < 200) begin
      vals = {u_if.out_val, u_if.Yin_val, u_if.Xin_val};
      for (int i = 0; i < 3; i++) begin
        if (vals[i]) begin
          if (!prev_v[i] && seen_hi[i] && low_run[i] < min_gap[i]) min_gap[i] = low_run[i];
          low_run[i] = 0;
          seen_hi[i] = 1'b1;
        end else begin
          low_run[i]++;
        end
        prev_v[i] = vals[i];
      end
      if (u_if.done) begin
        done_at[done_cnt] = cyc;
        done_cnt++;
        if (done_cnt == 3) u_if.start = 1'b0;
      end
      cyc++;
      if (done_cnt < 3) tick();
    end
    u_if.start = 1'b0;
    chk("t4 done pulses", done_cnt, 3);
    chk("t4 period 1-2", done_at[1] - done_at[0], 33);
    chk("t4 period 2-3", done_at[2] - done_at[1], 33);
    chk("t4 Xin gap>=2", (min_gap[0] >= 2), 1);
    chk("t4 Yin gap>=2", (min_gap[1] >= 2), 1);
    chk("t4 out gap>=2", (min_gap[2] >= 2), 1);
    tick();
    tick();
    chk("t4 idle after", u_if.busy, 0);
    $display("job t4: 3 jobs, done offsets %0d %0d %0d", done_at[0], done_at[1], done_at[2]);

    // Reset during LOAD cycle 5
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("t5 pre Xin_val", u_if.Xin_val, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("t5 Xin_val",   u_if.Xin_val,   0);
    chk("t5 Yin_val",   u_if.Yin_val,   0);
    chk("t5 a_rd_en",   u_if.a_rd_en,   0);
    chk("t5 b_rd_en",   u_if.b_rd_en,   0);
    chk("t5 a_rd_addr", u_if.a_rd_addr, 0);
    chk("t5 Xin_data",  u_if.Xin_data,  0);
    chk("t5 Yin_data",  u_if.Yin_data,  0);
    chk("t5 busy",      u_if.busy,      0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      done_cnt += int'(u_if.done);
    end
    sys_rst_n = 1'b1;
    tick();
    for (int c = 0; c < 30; c++) begin
      done_cnt += int'(u_if.done);
      tick();
    end
    chk("t5 no done", done_cnt, 0);
    $display("job t5: aborted by reset, rerunning");
    run_job("t5r");

    // Zero compute latency, X=2 N=5 Y=4
    u_if2.start = 1'b1;
    tick();
    u_if2.start = 1'b0;
    for (int c = 0; c < 34; c++) begin
      chk("t6 Xin_val",  u_if2.Xin_val,  (c < 10));
      chk("t6 Yin_val",  u_if2.Yin_val,  (c < 20));
      chk("t6 Xin_data", u_if2.Xin_data, (c >= 1 && c <= 10) ? c : 0);
      chk("t6 Yin_data", u_if2.Yin_data, (c >= 1 && c <= 20) ? c + 16 : 0);
      chk("t6 out_val",  u_if2.out_val,  (c >= 21 && c <= 28));
      chk("t6 c_wr_en",  u_if2.c_wr_en,  (c >= 22 && c <= 29));
      chk("t6 done",     u_if2.done,     (c == 30));
`ifdef RSA_STREAM_PERF_EN
      if (c >= 30) chk("t6 perf_cycles", perf2, 31);
`endif
      tick();
    end
    $display("job t6: zero-latency job complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
